// File: rtl/pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_sequencer
//  Purpose  : Drives the erase -> expose -> convert -> per-row read sequence
//             for an N_ROWS pixel array. Phase durations are programmable at
//             run time. Supports single-shot or continuous frames with a
//             start/busy/frame_done handshake and a synchronous abort.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous reset, active low
//             start      - frame request, honoured only while idle
//             mode       - 0 single-shot, 1 continuous (sampled per frame)
//             abort      - return to idle on the next edge
//             cfg_we/cfg_addr/cfg_data - duration register write port
//             erase/expose/convert - phase enables
//             read       - one-hot row read select
//             row_idx    - current read row index
//             busy       - high whenever a frame is in progress
//             frame_done - one-cycle pulse after the last row read
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_sequencer #(
    parameter int N_ROWS      = 4,
    parameter int CNT_W       = 8,
    parameter int ERASE_DEF   = 5,
    parameter int EXPOSE_DEF  = 255,
    parameter int CONVERT_DEF = 255,
    parameter int READ_DEF    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      abort,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_addr,
    input  logic [CNT_W-1:0]          cfg_data,
    output logic                      erase,
    output logic                      expose,
    output logic                      convert,
    output logic [N_ROWS-1:0]         read,
    output logic [$clog2(N_ROWS)-1:0] row_idx,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int c_ROW_W = $clog2(N_ROWS);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ERASE   = 3'd1;
    localparam logic [2:0] c_ST_EXPOSE  = 3'd2;
    localparam logic [2:0] c_ST_CONVERT = 3'd3;
    localparam logic [2:0] c_ST_READ    = 3'd4;

    // Programmed durations (writable at any time)
    logic [CNT_W-1:0]   r_dur_erase, r_dur_expose, r_dur_convert, r_dur_read;
    // Per-frame shadow copies; erase needs none because it is loaded at the
    // very edge the shadows are captured.
    logic [CNT_W-1:0]   r_sh_expose, r_sh_convert, r_sh_read;

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_ROW_W-1:0] r_row;
    logic               r_mode;
    logic               r_erase, r_expose, r_convert, r_busy, r_frame_done;
    logic [N_ROWS-1:0]  r_read;

    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [c_ROW_W-1:0] w_row_nxt;
    logic               w_mode_nxt;
    logic               w_latch;
    logic               w_done_nxt;

    // A programmed value of 0 behaves as 1: the counter still loads 0.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_mode_nxt  = r_mode;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_ERASE;
                    w_cnt_nxt   = f_load(r_dur_erase);
                    w_mode_nxt  = mode;
                    w_latch     = 1'b1;
                    w_row_nxt   = '0;
                end
            end
            c_ST_ERASE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_EXPOSE;
                    w_cnt_nxt   = f_load(r_sh_expose);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            c_ST_EXPOSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_CONVERT;
                    w_cnt_nxt   = f_load(r_sh_convert);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            c_ST_CONVERT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_READ;
                    w_cnt_nxt   = f_load(r_sh_read);
                    w_row_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            c_ST_READ: begin
                if (r_cnt == '0) begin
                    if (r_row == c_ROW_W'(N_ROWS - 1)) begin
                        w_done_nxt = 1'b1;
                        w_row_nxt  = '0;
                        if (r_mode) begin
                            // Back-to-back frame: fresh shadows and mode
                            w_state_nxt = c_ST_ERASE;
                            w_cnt_nxt   = f_load(r_dur_erase);
                            w_mode_nxt  = mode;
                            w_latch     = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_row_nxt = r_row + c_ROW_W'(1);
                        w_cnt_nxt = f_load(r_sh_read);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
                w_row_nxt   = '0;
            end
        endcase

        // Abort outranks every transition, but only once a frame is running
        if (abort && (r_state != c_ST_IDLE)) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
            w_latch     = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dur_erase   <= CNT_W'(ERASE_DEF);
            r_dur_expose  <= CNT_W'(EXPOSE_DEF);
            r_dur_convert <= CNT_W'(CONVERT_DEF);
            r_dur_read    <= CNT_W'(READ_DEF);
            r_sh_expose   <= CNT_W'(EXPOSE_DEF);
            r_sh_convert  <= CNT_W'(CONVERT_DEF);
            r_sh_read     <= CNT_W'(READ_DEF);
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_row         <= '0;
            r_mode        <= 1'b0;
            r_erase       <= 1'b0;
            r_expose      <= 1'b0;
            r_convert     <= 1'b0;
            r_read        <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    r_dur_erase   <= cfg_data;
                    2'd1:    r_dur_expose  <= cfg_data;
                    2'd2:    r_dur_convert <= cfg_data;
                    default: r_dur_read    <= cfg_data;
                endcase
            end
            // Shadows take the pre-write values at a frame-start edge
            if (w_latch) begin
                r_sh_expose  <= r_dur_expose;
                r_sh_convert <= r_dur_convert;
                r_sh_read    <= r_dur_read;
            end
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_row        <= w_row_nxt;
            r_mode       <= w_mode_nxt;
            r_erase      <= (w_state_nxt == c_ST_ERASE);
            r_expose     <= (w_state_nxt == c_ST_EXPOSE);
            r_convert    <= (w_state_nxt == c_ST_CONVERT);
            r_read       <= (w_state_nxt == c_ST_READ) ? (N_ROWS'(1) << w_row_nxt) : '0;
            r_busy       <= (w_state_nxt != c_ST_IDLE);
            r_frame_done <= w_done_nxt;
        end
    end

    assign erase      = r_erase;
    assign expose     = r_expose;
    assign convert    = r_convert;
    assign read       = r_read;
    assign row_idx    = r_row;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_sequencer
//  Purpose  : Self-checking bench for pixel_sequencer. A frame-level model
//             expands each frame into its list of per-cycle output vectors;
//             the expected vector for every clock edge goes into a queue and
//             an independent monitor compares it with the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sequencer;

    localparam int N_ROWS = 4;
    localparam int CNT_W  = 8;
    localparam int ROW_W  = $clog2(N_ROWS);
    localparam int VW     = 3 + N_ROWS + ROW_W + 2;

    typedef logic [VW-1:0] vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, mode, abort, cfg_we;
    logic [1:0]        cfg_addr;
    logic [CNT_W-1:0]  cfg_data;
    logic              erase, expose, convert, busy, frame_done;
    logic [N_ROWS-1:0] read;
    logic [ROW_W-1:0]  row_idx;

    pixel_sequencer #(
        .N_ROWS(N_ROWS), .CNT_W(CNT_W), .ERASE_DEF(5), .EXPOSE_DEF(255),
        .CONVERT_DEF(255), .READ_DEF(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .row_idx(row_idx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    vec_t exp_q[$];
    vec_t plan[$];
    bit   in_frame;
    bit   frame_mode;
    int   m_cfg[4];
    int   n_vec;
    int   n_err;
    vec_t last_exp;
    vec_t mon_exp;
    vec_t mon_act;

    function automatic vec_t mk(bit e, bit x, bit c, int row, bit b, bit d);
        logic [N_ROWS-1:0] rd;
        logic [ROW_W-1:0]  ri;
        rd = '0;
        ri = '0;
        if (row >= 0) begin
            rd[row] = 1'b1;
            ri      = ROW_W'(row);
        end
        return {e, x, c, rd, ri, b, d};
    endfunction

    function automatic vec_t dut_vec();
        return {erase, expose, convert, read, row_idx, busy, frame_done};
    endfunction

    // One frame = E erase cycles, X expose, C convert, then R per row.
    task automatic build_plan();
        int d;
        plan.delete();
        d = (m_cfg[0] == 0) ? 1 : m_cfg[0];
        repeat (d) plan.push_back(mk(1, 0, 0, -1, 1, 0));
        d = (m_cfg[1] == 0) ? 1 : m_cfg[1];
        repeat (d) plan.push_back(mk(0, 1, 0, -1, 1, 0));
        d = (m_cfg[2] == 0) ? 1 : m_cfg[2];
        repeat (d) plan.push_back(mk(0, 0, 1, -1, 1, 0));
        d = (m_cfg[3] == 0) ? 1 : m_cfg[3];
        for (int r = 0; r < N_ROWS; r++)
            repeat (d) plan.push_back(mk(0, 0, 0, r, 1, 0));
    endtask

    task automatic model_reset();
        plan.delete();
        in_frame   = 1'b0;
        frame_mode = 1'b0;
        m_cfg[0] = 5; m_cfg[1] = 255; m_cfg[2] = 255; m_cfg[3] = 5;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic step(input bit s, input bit m, input bit a, input bit we,
                        input logic [1:0] ad, input int dt);
        vec_t e;
        @(negedge clk);
        start = s; mode = m; abort = a; cfg_we = we; cfg_addr = ad;
        cfg_data = CNT_W'(dt);
        if (in_frame) begin
            if (a) begin
                plan.delete();
                in_frame = 1'b0;
                e = mk(0, 0, 0, -1, 0, 0);
            end else if (plan.size() > 0) begin
                e = plan.pop_front();
            end else if (frame_mode) begin
                build_plan();
                frame_mode = m;
                e = plan.pop_front();
                e[0] = 1'b1;
            end else begin
                in_frame = 1'b0;
                e = mk(0, 0, 0, -1, 0, 1);
            end
        end else if (s) begin
            build_plan();
            frame_mode = m;
            in_frame   = 1'b1;
            e = plan.pop_front();
        end else begin
            e = mk(0, 0, 0, -1, 0, 0);
        end
        if (we) m_cfg[ad] = dt;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic idle(input int n, input bit m);
        repeat (n) step(0, m, 0, 0, 2'd0, 0);
    endtask

    task automatic chk(input string name, input vec_t got, input vec_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compares every clock edge for which an expectation exists
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = dut_vec();
                n_vec++;
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL out_vec: got %b want %b at %0t", mon_act, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        int  cnt;
        bit  hit;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        start = 0; mode = 0; abort = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        #2;
        chk("reset_state", dut_vec(), mk(0, 0, 0, -1, 0, 0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Default single-shot frame with extra starts while busy
        step(1, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 545; i++)
            step((i == 100) || (i == 300) || (i == 530), 0, 0, 0, 2'd0, 0);

        // Continuous mode with small durations, mid-run expose change, then stop
        step(0, 1, 0, 1, 2'd0, 2);
        step(0, 1, 0, 1, 2'd1, 3);
        step(0, 1, 0, 1, 2'd2, 1);
        step(0, 1, 0, 1, 2'd3, 1);
        step(1, 1, 0, 0, 2'd0, 0);
        idle(13, 1);
        step(0, 1, 0, 1, 2'd1, 7);
        idle(25, 1);
        idle(30, 0);

        // Zero erase duration
        step(0, 0, 0, 1, 2'd0, 0);
        step(1, 0, 0, 0, 2'd0, 0);
        idle(25, 0);

        // Abort during row 2
        step(0, 0, 0, 1, 2'd3, 3);
        step(1, 0, 0, 0, 2'd0, 0);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (last_exp[VW-4 -: N_ROWS] == N_ROWS'(4)) begin
                step(0, 0, 1, 0, 2'd0, 0);
                hit = 1'b1;
            end else begin
                idle(1, 0);
            end
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL abort_window: got no row-2 cycle want one");
        end
        idle(3, 0);
        step(1, 0, 0, 0, 2'd0, 0);
        idle(35, 0);

        // Start together with abort while idle
        step(1, 0, 1, 0, 2'd0, 0);
        idle(4, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        step(0, 0, 1, 0, 2'd0, 0);
        idle(2, 0);

        // Asynchronous reset in the middle of expose
        step(0, 0, 0, 1, 2'd0, 2);
        step(0, 0, 0, 1, 2'd1, 20);
        step(1, 0, 0, 0, 2'd0, 0);
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            idle(1, 0);
            if (last_exp[VW-2]) cnt++;
        end
        @(posedge clk);
        #3;
        chk("pre_reset_expose", {{(VW-2){1'b0}}, expose, busy}, {{(VW-2){1'b0}}, 2'b11});
        reset = 1'b0;
        #1;
        chk("async_reset_clear", dut_vec(), mk(0, 0, 0, -1, 0, 0));
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0, 0, 2'd0, 0);
        idle(540, 0);

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
